// File: rtl/run_detector.sv
// run_detector: counts consecutive 1s on w and raises z in one-shot, level, exact or periodic mode.
module run_detector #(
  parameter int N  = 1,
  parameter int CW = 4,
  parameter int HW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [1:0]    mode,
  input  logic          w,
  output logic          z,
  output logic [CW-1:0] run_len,
  output logic [HW-1:0] hits
);
  localparam logic [CW-1:0] NV   = CW'(N);
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [HW-1:0] HMAX = '1;
  logic [CW-1:0] cnt_q, cnt_d, ph_q, ph_d;
  logic [HW-1:0] hits_q, hits_d;
  logic          z_q, z_d;
  always_comb begin
    cnt_d  = cnt_q;
    ph_d   = ph_q;
    z_d    = z_q;
    hits_d = hits_q;
    if (clr) begin
      cnt_d  = '0;
      ph_d   = '0;
      z_d    = 1'b0;
      hits_d = '0;
    end else if (en) begin
      cnt_d  = w ? (cnt_q == CMAX ? cnt_q : cnt_q + 1'b1) : '0;
      ph_d   = w ? (ph_q == NV ? CW'(1) : ph_q + 1'b1) : '0;
      // EXACT looks at the pre-update count so it fires on the terminating 0
      z_d    = mode == 2'd0 ? cnt_d == NV :
               mode == 2'd1 ? cnt_d >= NV :
               mode == 2'd2 ? !w && cnt_q == NV :
                              w && ph_d == NV;
      hits_d = (z_d && !z_q && hits_q != HMAX) ? hits_q + 1'b1 : hits_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      ph_q   <= '0;
      z_q    <= 1'b0;
      hits_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      ph_q   <= ph_d;
      z_q    <= z_d;
      hits_q <= hits_d;
    end
  end
  assign z       = z_q;
  assign run_len = cnt_q;
  assign hits    = hits_q;
endmodule

// File: tb/tb_run_detector.sv
// tb_run_detector: directed checks of run_detector across modes, saturation and control inputs.
module tb_run_detector;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b1;
  logic clr = 1'b0;
  logic [1:0] mode = 2'd0;
  logic w = 1'b0;
  logic z1, z2, z3, z7;
  logic [3:0] rl1, rl2, rl3;
  logic [2:0] rl7;
  logic [7:0] h1, h2, h3, h7;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  run_detector #(.N(1)) d1 (.clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .w(w), .z(z1), .run_len(rl1), .hits(h1));
  run_detector #(.N(2)) d2 (.clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .w(w), .z(z2), .run_len(rl2), .hits(h2));
  run_detector #(.N(3)) d3 (.clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .w(w), .z(z3), .run_len(rl3), .hits(h3));
  run_detector #(.N(3), .CW(3)) d7 (.clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .w(w), .z(z7), .run_len(rl7), .hits(h7));

  task automatic step(input logic wi);
    w = wi;
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    clr = 1'b1;
    w = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    checks++;
    if ({z1, z2, z3, z7, rl1, rl2, rl3, rl7, h1, h2, h3, h7} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got z=%b%b%b%b run_len=%0d/%0d/%0d/%0d exp all 0", z1, z2, z3, z7, rl1, rl2, rl3, rl7);
    end
    #4 rst = 1'b0;
  endtask

  task automatic test_one_shot();
    int ws[5] = '{0, 1, 1, 0, 1};
    int ez[5] = '{0, 1, 0, 0, 1};
    int eh[5] = '{0, 1, 1, 1, 2};
    mode = 2'd0;
    clear();
    for (int i = 0; i < 5; i++) begin
      step(1'(ws[i]));
      checks += 2;
      if (z1 !== 1'(ez[i])) begin failures++; $display("FAIL one_shot_z[%0d] got=%b exp=%0d", i, z1, ez[i]); end
      if (h1 !== 8'(eh[i])) begin failures++; $display("FAIL one_shot_hits[%0d] got=%0d exp=%0d", i, h1, eh[i]); end
    end
  endtask

  task automatic test_level();
    int ws[6] = '{1, 1, 1, 1, 1, 0};
    int er[6] = '{1, 2, 3, 4, 5, 0};
    int ez[6] = '{0, 0, 1, 1, 1, 0};
    mode = 2'd1;
    clear();
    for (int i = 0; i < 6; i++) begin
      step(1'(ws[i]));
      checks += 2;
      if (rl3 !== 4'(er[i])) begin failures++; $display("FAIL level_run_len[%0d] got=%0d exp=%0d", i, rl3, er[i]); end
      if (z3 !== 1'(ez[i])) begin failures++; $display("FAIL level_z[%0d] got=%b exp=%0d", i, z3, ez[i]); end
    end
    checks++;
    if (h3 !== 8'd1) begin failures++; $display("FAIL level_hits got=%0d exp=1", h3); end
  endtask

  task automatic test_exact();
    int ws[10] = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 0};
    int ez[10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    int eh[10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 2};
    mode = 2'd2;
    clear();
    for (int i = 0; i < 10; i++) begin
      step(1'(ws[i]));
      checks += 2;
      if (z2 !== 1'(ez[i])) begin failures++; $display("FAIL exact_z[%0d] got=%b exp=%0d", i, z2, ez[i]); end
      if (h2 !== 8'(eh[i])) begin failures++; $display("FAIL exact_hits[%0d] got=%0d exp=%0d", i, h2, eh[i]); end
    end
  endtask

  task automatic test_periodic();
    int ez[7] = '{0, 0, 1, 0, 0, 1, 0};
    int eh[7] = '{0, 0, 1, 1, 1, 2, 2};
    mode = 2'd3;
    clear();
    for (int i = 0; i < 7; i++) begin
      step(1'b1);
      checks += 2;
      if (z3 !== 1'(ez[i])) begin failures++; $display("FAIL periodic_z[%0d] got=%b exp=%0d", i, z3, ez[i]); end
      if (h3 !== 8'(eh[i])) begin failures++; $display("FAIL periodic_hits[%0d] got=%0d exp=%0d", i, h3, eh[i]); end
    end
  endtask

  task automatic test_periodic_n1();
    mode = 2'd3;
    clear();
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      checks += 2;
      if (z1 !== 1'b1) begin failures++; $display("FAIL periodic_n1_z[%0d] got=%b exp=1", i, z1); end
      if (h1 !== 8'd1) begin failures++; $display("FAIL periodic_n1_hits[%0d] got=%0d exp=1", i, h1); end
    end
  endtask

  task automatic test_saturation();
    int er[10] = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 7};
    int ep[10] = '{1, 2, 3, 1, 2, 3, 1, 2, 3, 1};
    mode = 2'd2;
    clear();
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      checks += 3;
      if (rl7 !== 3'(er[i])) begin failures++; $display("FAIL sat_run_len[%0d] got=%0d exp=%0d", i, rl7, er[i]); end
      if (d7.ph_q !== 3'(ep[i])) begin failures++; $display("FAIL sat_ph[%0d] got=%0d exp=%0d", i, d7.ph_q, ep[i]); end
      if (z7 !== 1'b0) begin failures++; $display("FAIL sat_z[%0d] got=%b exp=0", i, z7); end
    end
    step(1'b0);
    checks += 3;
    if (z7 !== 1'b0) begin failures++; $display("FAIL sat_term_z got=%b exp=0", z7); end
    if (rl7 !== 3'd0) begin failures++; $display("FAIL sat_term_run_len got=%0d exp=0", rl7); end
    if (h7 !== 8'd0) begin failures++; $display("FAIL sat_term_hits got=%0d exp=0", h7); end
  endtask

  task automatic test_control();
    mode = 2'd1;
    clear();
    step(1'b1);
    step(1'b1);
    checks += 3;
    if (rl2 !== 4'd2 || z2 !== 1'b1 || h2 !== 8'd1) begin failures++; $display("FAIL ctl_pre run_len=%0d z=%b hits=%0d exp 2/1/1", rl2, z2, h2); end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'(i != 1));
      checks++;
      if (rl2 !== 4'd2 || z2 !== 1'b1 || h2 !== 8'd1) begin failures++; $display("FAIL ctl_hold[%0d] run_len=%0d z=%b hits=%0d exp 2/1/1", i, rl2, z2, h2); end
    end
    en = 1'b1;
    step(1'b1);
    checks++;
    if (rl2 !== 4'd3 || z2 !== 1'b1) begin failures++; $display("FAIL ctl_resume run_len=%0d z=%b exp 3/1", rl2, z2); end
    clr = 1'b1;
    step(1'b1);
    clr = 1'b0;
    checks++;
    if (rl2 !== 4'd0 || z2 !== 1'b0 || h2 !== 8'd0) begin failures++; $display("FAIL ctl_clr run_len=%0d z=%b hits=%0d exp 0/0/0", rl2, z2, h2); end
    step(1'b1);
    step(1'b1);
    checks++;
    if (rl2 !== 4'd2 || z2 !== 1'b1 || h2 !== 8'd1) begin failures++; $display("FAIL ctl_run run_len=%0d z=%b hits=%0d exp 2/1/1", rl2, z2, h2); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rl2 !== 4'd0 || z2 !== 1'b0 || h2 !== 8'd0) begin failures++; $display("FAIL ctl_async_rst run_len=%0d z=%b hits=%0d exp 0/0/0", rl2, z2, h2); end
    #1 rst = 1'b0;
    step(1'b1);
    checks++;
    if (rl2 !== 4'd1 || z2 !== 1'b0 || h2 !== 8'd0) begin failures++; $display("FAIL ctl_post_rst1 run_len=%0d z=%b hits=%0d exp 1/0/0", rl2, z2, h2); end
    step(1'b1);
    checks++;
    if (rl2 !== 4'd2 || z2 !== 1'b1 || h2 !== 8'd1) begin failures++; $display("FAIL ctl_post_rst2 run_len=%0d z=%b hits=%0d exp 2/1/1", rl2, z2, h2); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_level();
    test_exact();
    test_periodic();
    test_periodic_n1();
    test_saturation();
    test_control();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
